// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Sequencing controller for the multiply/divide unit behind the
//            E stage. Owns the HI/LO registers and the latency counter,
//            raises the MDU stall request for the D->E pipeline register and
//            drops MDU starts that coincide with an exception flush so a
//            flushed instruction never commits to HI/LO.
// Ports    : clk       - clock, all state updates on posedge
//            reset     - synchronous active-high reset
//            Req       - exception/interrupt flush request
//            E_start   - E-stage instruction is an MDU operation
//            E_mdop    - 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo
//            E_A, E_B  - forwarded GPR[rs], GPR[rt]
//            D_md_use  - D-stage instruction uses the MDU or HI/LO
//            Busy      - MDU operation in flight
//            Stall_md  - combinational stall request to hazard logic
//            HI, LO    - architectural HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        E_start,
    input  logic [2:0]  E_mdop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        Busy,
    output logic        Stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]          r_phi;
    logic [31:0]          r_plo;
    logic [31:0]          w_phi_nxt;
    logic [31:0]          w_plo_nxt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          w_hi_nxt;
    logic [31:0]          w_lo_nxt;

    // ------------------------------------------------------------------
    // Datapath: one shared 64-bit multiplier and a sign-magnitude divider.
    // ------------------------------------------------------------------
    logic        w_is_arith;
    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic        w_b_zero;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_is_arith = (E_mdop >= c_OP_MULT) && (E_mdop <= c_OP_DIVU);
    assign w_signed   = (E_mdop == c_OP_MULT) || (E_mdop == c_OP_DIV);

    // The low 64 bits of a 64x64 product of extended operands equal the
    // 32x32 signed or unsigned product, depending on the extension used.
    assign w_a_ext = {{32{w_signed & E_A[31]}}, E_A};
    assign w_b_ext = {{32{w_signed & E_B[31]}}, E_B};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide magnitudes, then fix signs: quotient truncates toward zero and
    // the remainder follows the dividend. 0x80000000 / -1 wraps naturally.
    assign w_a_neg  = w_signed & E_A[31];
    assign w_b_neg  = w_signed & E_B[31];
    assign w_a_mag  = w_a_neg ? (~E_A + 32'd1) : E_A;
    assign w_b_mag  = w_b_neg ? (~E_B + 32'd1) : E_B;
    assign w_b_zero = (E_B == 32'd0);
    assign w_b_safe = w_b_zero ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phi_nxt   = r_phi;
        w_plo_nxt   = r_plo;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;

        case (r_state)
            ST_IDLE: begin
                // A flush cancels whatever is in E this cycle.
                if (E_start && !Req) begin
                    case (E_mdop)
                        c_OP_MULT, c_OP_MULTU: begin
                            w_phi_nxt   = w_prod[63:32];
                            w_plo_nxt   = w_prod[31:0];
                            w_cnt_nxt   = c_MULT_LOAD;
                            w_state_nxt = ST_RUN;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            // Divide by zero leaves HI/LO as they are.
                            w_phi_nxt   = w_b_zero ? r_hi : w_rem;
                            w_plo_nxt   = w_b_zero ? r_lo : w_quot;
                            w_cnt_nxt   = c_DIV_LOAD;
                            w_state_nxt = ST_RUN;
                        end
                        c_OP_MTHI: w_hi_nxt = E_A;
                        c_OP_MTLO: w_lo_nxt = E_A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // A running op belongs to an older, committed instruction,
                // so neither Req nor a new E_start affects it.
                if (r_cnt == c_CNT_ONE) begin
                    w_hi_nxt    = r_phi;
                    w_lo_nxt    = r_plo;
                    w_cnt_nxt   = c_CNT_ZERO;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= c_CNT_ZERO;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phi   <= w_phi_nxt;
            r_plo   <= w_plo_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign Busy     = (r_state == ST_RUN);
    assign HI       = r_hi;
    assign LO       = r_lo;
    // Stall on an op already running and on one being started this cycle,
    // so the dependent instruction sees no gap before Busy rises.
    assign Stall_md = D_md_use && (Busy || (E_start && w_is_arith));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Self-checking bench for mdu_ctrl. Directed scenarios followed
//            by randomized cycles, compared against a cycle-level reference
//            model built from plain 64-bit arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic        E_start;
    logic [2:0]  E_mdop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_md_use;
    logic        Busy;
    logic        Stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    mdu_ctrl #(
        .MULT_CYCLES (c_MULT),
        .DIV_CYCLES  (c_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Req      (Req),
        .E_start  (E_start),
        .E_mdop   (E_mdop),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_md_use (D_md_use),
        .Busy     (Busy),
        .Stall_md (Stall_md),
        .HI       (HI),
        .LO       (LO)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_ph = 32'd0;
    logic [31:0] m_pl = 32'd0;
    int          m_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] cur_hi,
                                       input logic [31:0] cur_lo,
                                       output logic [31:0] ph, output logic [31:0] pl);
        longint          sa;
        longint          sb;
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ph = cur_hi;
        pl = cur_lo;
        case (op)
            3'd1: begin sp = sa * sb; ph = sp[63:32]; pl = sp[31:0]; end
            3'd2: begin up = ua * ub; ph = up[63:32]; pl = up[31:0]; end
            3'd3: if (b != 32'd0) begin
                sq = sa / sb; sr = sa % sb; ph = sr[31:0]; pl = sq[31:0];
            end
            3'd4: if (b != 32'd0) begin
                up = ua / ub; ph = 32'(ua % ub); pl = up[31:0];
            end
            default: ;
        endcase
    endfunction

    // One clock cycle: drive inputs, check the combinational stall, clock,
    // advance the model and compare registered outputs.
    task automatic step(input logic rs, input logic rq, input logic st,
                        input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic du);
        logic exp_stall;
        reset = rs; Req = rq; E_start = st; E_mdop = op; E_A = a; E_B = b; D_md_use = du;
        #1;
        exp_stall = du && ((m_left > 0) || (st && op >= 3'd1 && op <= 3'd4));
        chk("stall", {31'd0, Stall_md}, {31'd0, exp_stall});
        @(posedge clk);
        if (rs) begin
            m_hi = 32'd0; m_lo = 32'd0; m_ph = 32'd0; m_pl = 32'd0; m_left = 0;
        end else if (m_left > 0) begin
            if (m_left == 1) begin m_hi = m_ph; m_lo = m_pl; end
            m_left--;
        end else if (st && !rq) begin
            case (op)
                3'd1, 3'd2: begin ref_result(op, a, b, m_hi, m_lo, m_ph, m_pl); m_left = c_MULT; end
                3'd3, 3'd4: begin ref_result(op, a, b, m_hi, m_lo, m_ph, m_pl); m_left = c_DIV; end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
        #1;
        chk("busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, du);
    endtask

    initial begin
        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        idle(1, 1'b1);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        // mult -2 * 3 with a dependent instruction waiting in D
        step(1'b0, 1'b0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle(c_MULT, 1'b1);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        // divu 100 / 7
        step(1'b0, 1'b0, 1'b1, 3'd4, 32'd100, 32'd7, 1'b1);
        idle(c_DIV, 1'b0);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);

        // div -7 / 2
        step(1'b0, 1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(c_DIV, 1'b0);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        // divide by zero keeps HI/LO
        step(1'b0, 1'b0, 1'b1, 3'd3, 32'd5, 32'd0, 1'b0);
        idle(c_DIV, 1'b0);
        chk("div0_lo", LO, 32'hFFFF_FFFD);
        chk("div0_hi", HI, 32'hFFFF_FFFF);

        // mthi then mtlo back to back
        step(1'b0, 1'b0, 1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 3'd6, 32'd9, 32'd0, 1'b0);
        chk("mthi", HI, 32'h1234_5678);
        chk("mtlo", LO, 32'd9);

        // start cancelled by flush
        step(1'b0, 1'b1, 1'b1, 3'd1, 32'd5, 32'd5, 1'b0);
        chk("flush_lo", LO, 32'd9);

        // flush during cycle 2 of a running div: 100 / -3
        step(1'b0, 1'b0, 1'b1, 3'd3, 32'd100, 32'hFFFF_FFFD, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd1, 32'd7, 32'd7, 1'b0);
        idle(c_DIV - 2, 1'b0);
        chk("divreq_lo", LO, 32'hFFFF_FFDF);
        chk("divreq_hi", HI, 32'd1);

        // mthi issued while a mult is running is ignored
        step(1'b0, 1'b0, 1'b1, 3'd2, 32'd7, 32'd6, 1'b1);
        step(1'b0, 1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        idle(c_MULT - 1, 1'b0);
        chk("busyign_hi", HI, 32'd0);
        chk("busyign_lo", LO, 32'd42);

        // reset on cycle 3 of a running mult, then no late write
        step(1'b0, 1'b0, 1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        idle(10, 1'b0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_rs;
            logic        r_rq;
            logic        r_st;
            logic [2:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_rs = ($urandom % 64) == 0;
            r_rq = ($urandom % 8) == 0;
            r_st = ($urandom % 2) == 0;
            r_op = 3'($urandom % 8);
            r_a  = (($urandom % 3) == 0) ? 32'($urandom % 200) - 32'd100 : $urandom;
            case ($urandom % 6)
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_b = 32'($urandom % 16) + 32'd1;
                default: r_b = $urandom;
            endcase
            if (($urandom % 32) == 0) r_a = 32'h8000_0000;
            step(r_rs, r_rq, r_st, r_op, r_a, r_b, 1'($urandom % 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
